// File: rtl/rr_lock_arbiter_pkg.sv
// Shared types and helpers for the round-robin lock arbiter.
//   arb_state_t    - FSM encoding (IDLE / GRANT / LOCKED)
//   lock_cnt_width - width of the lock counter for a given MAX_LOCK (at least 1 bit)
//   rotl_onehot    - rotate an n-bit one-hot vector left by one, with wrap-around
package rr_lock_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        LOCKED
    } arb_state_t;

    // $clog2(max_lock+1), widened to 1 bit for the unlimited (0) case so the
    // counter always exists.
    function automatic int unsigned lock_cnt_width(input int unsigned max_lock);
        return (max_lock == 0) ? 1 : $clog2(max_lock + 1);
    endfunction

    // Operates on the low n bits of a 32-bit container; upper bits are cleared.
    function automatic logic [31:0] rotl_onehot(input logic [31:0] v, input int unsigned n);
        logic [31:0] mask;
        mask = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
        return ((v << 1) | (v >> (n - 1))) & mask;
    endfunction

endpackage

// File: rtl/one_hot_to_integer.sv
// Common component: converts a one-hot (or all-zero) vector to its binary index.
//   one_hot  in   WIDTH   one-hot input; all-zero yields index 0
//   idx      out  ID_W    binary index of the set bit
module one_hot_to_integer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [WIDTH-1:0] one_hot,
    output logic [ID_W-1:0]  idx
);

    // OR-reduction of indices: exact for one-hot, zero for an empty vector.
    always_comb begin
        idx = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (one_hot[i]) begin
                idx = idx | ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter sharing one resource between NUM_REQ requesters, with an
// optional per-requester lock that lets a winner hold the resource for up to
// MAX_LOCK consecutive acked transfers (0 = unlimited).
//   clk          in   1        clock
//   rst          in   1        synchronous active-high reset
//   request      in   NUM_REQ  per-requester request, held until its ack
//   lock         in   NUM_REQ  per-requester lock hint, sampled at ack
//   ack          in   1        resource accepts the presented grant
//   grant        out  NUM_REQ  registered one-hot grant, zero when invalid
//   grant_valid  out  1        a grant is being presented
//   grant_id     out  ID_W     binary index of grant, zero when invalid
module rr_lock_arbiter
    import rr_lock_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MAX_LOCK = 8,
    localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] request,
    input  logic [NUM_REQ-1:0] lock,
    input  logic               ack,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id
);

    localparam int unsigned LOCK_CNT_W = lock_cnt_width(MAX_LOCK);

    arb_state_t              state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [NUM_REQ-1:0]      ptr_q, ptr_d;
    logic [LOCK_CNT_W-1:0]   lock_cnt_q, lock_cnt_d;

    logic                    win_req;
    logic                    win_lock;
    logic                    lock_ok;
    logic [NUM_REQ-1:0]      others;
    logic [NUM_REQ-1:0]      ptr_next;

    // Two-pass priority: lowest set bit at/above the pointer, else lowest set bit overall.
    function automatic logic [NUM_REQ-1:0] pick(input logic [NUM_REQ-1:0] req,
                                                input logic [NUM_REQ-1:0] ptr);
        logic [NUM_REQ-1:0] hi;
        logic [NUM_REQ-1:0] masked;
        logic [NUM_REQ-1:0] src;
        hi     = ~(ptr - NUM_REQ'(1));
        masked = req & hi;
        src    = (|masked) ? masked : req;
        return src & (~src + NUM_REQ'(1));
    endfunction

    assign win_req  = |(request & grant_q);
    assign win_lock = |(lock & grant_q);
    assign others   = request & ~grant_q;
    assign ptr_next = NUM_REQ'(rotl_onehot(32'(grant_q), NUM_REQ));
    // Staying locked is allowed only while this ack is not the last one permitted.
    assign lock_ok  = (MAX_LOCK == 0) ? 1'b1 : ((32'(lock_cnt_q) + 32'd1) < MAX_LOCK);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers owned by the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q    <= '0;
            ptr_q      <= NUM_REQ'(1);
            lock_cnt_q <= '0;
        end else begin
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        lock_cnt_d = lock_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|request) begin
                    grant_d = pick(request, ptr_q);
                    state_d = GRANT;
                end
            end
            GRANT, LOCKED: begin
                if (ack) begin
                    if (win_lock && win_req && lock_ok) begin
                        state_d    = LOCKED;
                        // Saturate so the unlimited case cannot wrap.
                        lock_cnt_d = (&lock_cnt_q) ? lock_cnt_q : lock_cnt_q + LOCK_CNT_W'(1);
                    end else begin
                        ptr_d      = ptr_next;
                        lock_cnt_d = '0;
                        // Re-arbitrate immediately so back-to-back grants have no bubble.
                        if (|others) begin
                            grant_d = pick(others, ptr_next);
                            state_d = GRANT;
                        end else begin
                            grant_d = '0;
                            state_d = IDLE;
                        end
                    end
                end else if (!win_req) begin
                    // Winner withdrew before ack: drop the grant, keep the pointer.
                    grant_d    = '0;
                    lock_cnt_d = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                grant_d    = '0;
                lock_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        grant       = grant_q;
        grant_valid = (state_q != IDLE);
    end

    one_hot_to_integer #(
        .WIDTH (NUM_REQ),
        .ID_W  (ID_W)
    ) u_grant_id (
        .one_hot (grant_q),
        .idx     (grant_id)
    );

    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_grant_iff_valid: assert property (@(posedge clk) disable iff (rst)
        ((grant != '0) == grant_valid));
    a_grant_stable: assert property (@(posedge clk) disable iff (rst)
        (grant_valid && !ack && |(request & grant)) |=> $stable(grant));
    a_ack_needs_grant: assert property (@(posedge clk) disable iff (rst) ack |-> grant_valid);

endmodule

// File: tb/tb_rr_lock_arbiter.sv
module tb_rr_lock_arbiter;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned MAX_LOCK = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] request;
    logic [3:0] lock;
    logic       ack;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_lock_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .request     (request),
        .lock        (lock),
        .ack         (ack),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected grant_valid and grant_id follow from the expected one-hot grant.
    task automatic expect_grant(input string tag, input logic [3:0] g);
        logic [1:0] id;
        id = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) id = 2'(i);
        end
        check({tag, " grant"}, 32'(grant), 32'(g));
        check({tag, " valid"}, 32'(grant_valid), 32'(g != 4'b0000));
        check({tag, " id"}, 32'(grant_id), 32'(id));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; request = 4'b0000; lock = 4'b0000; ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        expect_grant("reset", 4'b0000);

        // Contention: full rotation with ack every cycle
        request = 4'b1111;
        tick();
        expect_grant("cont0", 4'b0001);
        ack = 1'b1;
        tick(); expect_grant("cont1", 4'b0010);
        tick(); expect_grant("cont2", 4'b0100);
        tick(); expect_grant("cont3", 4'b1000);
        tick(); expect_grant("cont4", 4'b0001);

        // Abort on requester 0 leaves pointer at 0001
        ack = 1'b0; request = 4'b0000;
        tick(); expect_grant("abort0", 4'b0000);

        // Lock limit: requester 0 holds for exactly 3 acks
        request = 4'b0011; lock = 4'b0001;
        tick(); expect_grant("lockA0", 4'b0001);
        ack = 1'b1;
        tick(); expect_grant("lockA1", 4'b0001);
        tick(); expect_grant("lockA2", 4'b0001);
        tick(); expect_grant("lockA3", 4'b0010);
        // 0010 released (not locking); pointer 0100 falls back to req0
        tick(); expect_grant("lockB0", 4'b0001);
        // Counter was cleared: another full 3-ack hold
        tick(); expect_grant("lockB1", 4'b0001);
        tick(); expect_grant("lockB2", 4'b0001);
        tick(); expect_grant("lockB3", 4'b0010);
        // Abort requester 1; pointer stays 0010
        ack = 1'b0; lock = 4'b0000; request = 4'b0000;
        tick(); expect_grant("abort1", 4'b0000);

        // Stall: grant stable while ack is low
        request = 4'b0110;
        tick(); expect_grant("stall0", 4'b0010);
        for (int i = 1; i < 5; i++) begin
            tick(); expect_grant("stall", 4'b0010);
        end
        ack = 1'b1;
        tick(); expect_grant("stall_ack", 4'b0100);

        // Abort requester 2 with ack low; pointer must remain 0100
        ack = 1'b0; request = 4'b0010;
        tick(); expect_grant("abort2", 4'b0000);
        request = 4'b0110;
        tick(); expect_grant("ptr_kept", 4'b0100);

        // Ack plus new requests in the same cycle; then wrap 1000 -> 0001
        ack = 1'b1; request = 4'b1001;
        tick(); expect_grant("wrap0", 4'b1000);
        tick(); expect_grant("wrap1", 4'b0001);

        // Reset while LOCKED
        request = 4'b0001; lock = 4'b0001;
        tick(); expect_grant("locked", 4'b0001);
        rst = 1'b1; ack = 1'b0;
        tick(); expect_grant("rst_mid", 4'b0000);
        rst = 1'b0; request = 4'b0011;
        tick(); expect_grant("postrst0", 4'b0001);
        ack = 1'b1;
        tick(); expect_grant("postrst1", 4'b0001);
        tick(); expect_grant("postrst2", 4'b0001);
        tick(); expect_grant("postrst3", 4'b0010);
        ack = 1'b0; lock = 4'b0000; request = 4'b0000;
        tick(); expect_grant("end", 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
